// File: rtl/int_div_radix.sv
// Iterative radix-2^STEP restoring integer divider with signed/unsigned and rv32 word modes.
// Define INT_DIV_EARLY_EXIT_EN to let divide-by-zero and signed overflow skip the iteration phase.
module int_div_radix #(
    parameter int WIDTH = 64,
    parameter int STEP  = 4
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_ena,
    input  logic             i_unsigned,
    input  logic             i_rv32,
    input  logic             i_residual,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_a2,
    output logic [WIDTH-1:0] o_res,
    output logic             o_valid,
    output logic             o_busy
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_CORR = 2'd2} state_t;

    localparam logic             HAS_RV  = (WIDTH > 32);
    localparam logic [6:0]       CNT_W   = 7'(WIDTH / STEP - 1);
    localparam logic [6:0]       CNT_32  = 7'(32 / STEP - 1);
    localparam logic [WIDTH-1:0] MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_32  = WIDTH'(32'h8000_0000);
    localparam logic [WIDTH-1:0] ONES_W  = '1;
    localparam logic [WIDTH-1:0] ONES_32 = WIDTH'(32'hFFFF_FFFF);

    function automatic logic [WIDTH-1:0] fn_zext32(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r       = '0;
        r[31:0] = x[31:0];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] fn_sext32(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        r = x;
        for (int i = 32; i < WIDTH; i++) r[i] = x[31];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] fn_neg(input logic [WIDTH-1:0] x, input logic en);
        return en ? -x : x;
    endfunction

    state_t           r_state;
    logic [6:0]       r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_a1x;
    logic [WIDTH-1:0] r_res_p0;
    logic             r_vld_p0;
    logic             r_rv;
    logic             r_resid;
    logic             r_negq;
    logic             r_negr;
    logic             r_dz;
    logic             r_ovf;

    logic             w_rv;
    logic             w_go;
    logic             w_neg1;
    logic             w_neg2;
    logic             w_dz;
    logic             w_ovf;
    logic             w_early;
    logic [WIDTH-1:0] w_a1n;
    logic [WIDTH-1:0] w_a2n;
    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [WIDTH-1:0] w_qinit;

    // Operand capture: truncate to the active width and split into sign and magnitude
    assign w_rv    = HAS_RV & i_rv32;
    assign w_go    = i_ena & ~o_busy & (r_state == S_IDLE);
    assign w_a1n   = w_rv ? fn_zext32(i_a1) : i_a1;
    assign w_a2n   = w_rv ? fn_zext32(i_a2) : i_a2;
    assign w_neg1  = ~i_unsigned & (w_rv ? i_a1[31] : i_a1[WIDTH-1]);
    assign w_neg2  = ~i_unsigned & (w_rv ? i_a2[31] : i_a2[WIDTH-1]);
    assign w_mag1  = w_rv ? fn_zext32(fn_neg(w_a1n, w_neg1)) : fn_neg(w_a1n, w_neg1);
    assign w_mag2  = w_rv ? fn_zext32(fn_neg(w_a2n, w_neg2)) : fn_neg(w_a2n, w_neg2);
    assign w_dz    = (w_a2n == '0);
    assign w_ovf   = ~i_unsigned & (w_a1n == (w_rv ? MIN_32 : MIN_W))
                                 & (w_a2n == (w_rv ? ONES_32 : ONES_W));
    // A 32-bit dividend sits at the top so quotient bits emerge in the low word
    assign w_qinit = w_rv ? (w_mag1 << (WIDTH - 32)) : w_mag1;

`ifdef INT_DIV_EARLY_EXIT_EN
    assign w_early = w_dz | w_ovf;
`else
    assign w_early = 1'b0;
`endif

    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_q_nx;
    logic [WIDTH:0]   w_trial;

    always_comb begin
        w_rem_nx = r_rem;
        w_q_nx   = r_q;
        w_trial  = '0;
        for (int i = 0; i < STEP; i++) begin
            w_trial = {w_rem_nx, w_q_nx[WIDTH-1]};
            w_q_nx  = {w_q_nx[WIDTH-2:0], 1'b0};
            if (w_trial >= {1'b0, r_div}) begin
                w_trial   = w_trial - {1'b0, r_div};
                w_q_nx[0] = 1'b1;
            end
            w_rem_nx = w_trial[WIDTH-1:0];
        end
    end

    logic [WIDTH-1:0] w_qf;
    logic [WIDTH-1:0] w_rf;
    logic [WIDTH-1:0] w_corr;

    // Sign correction and special-case override
    always_comb begin
        w_qf = fn_neg(r_rv ? fn_zext32(r_q) : r_q, r_negq);
        w_rf = fn_neg(r_rem, r_negr);
        if (r_rv) begin
            w_qf = fn_sext32(w_qf);
            w_rf = fn_sext32(w_rf);
        end
        if (r_dz) begin
            w_qf = '1;
            w_rf = r_a1x;
        end else if (r_ovf) begin
            w_qf = r_a1x;
            w_rf = '0;
        end
        w_corr = r_resid ? w_rf : w_qf;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_div    <= '0;
            r_a1x    <= '0;
            r_res_p0 <= '0;
            r_vld_p0 <= 1'b0;
            r_rv     <= 1'b0;
            r_resid  <= 1'b0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            o_res    <= '0;
            o_valid  <= 1'b0;
            o_busy   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            // Output stage: publish the corrected result one cycle after CORR
            if (r_vld_p0) begin
                o_res    <= r_res_p0;
                o_valid  <= 1'b1;
                o_busy   <= 1'b0;
                r_vld_p0 <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_rv    <= w_rv;
                        r_resid <= i_residual;
                        r_negq  <= w_neg1 ^ w_neg2;
                        r_negr  <= w_neg1;
                        r_dz    <= w_dz;
                        r_ovf   <= w_ovf;
                        r_a1x   <= w_rv ? fn_sext32(i_a1) : i_a1;
                        r_div   <= w_mag2;
                        r_rem   <= '0;
                        r_q     <= w_qinit;
                        r_cnt   <= w_rv ? CNT_32 : CNT_W;
                        o_busy  <= 1'b1;
                        r_state <= w_early ? S_CORR : S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_q   <= w_q_nx;
                    r_cnt <= r_cnt - 7'd1;
                    if (r_cnt == 7'd0) r_state <= S_CORR;
                end
                S_CORR: begin
                    r_res_p0 <= w_corr;
                    r_vld_p0 <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int_div_radix.sv
// Directed and reference-model bench for int_div_radix (STEP=4 main instance, STEP=2/1 sweep instances).
module tb_int_div_radix;
`ifdef INT_DIV_EARLY_EXIT_EN
    localparam int LZ64 = 2;
    localparam int LZ32 = 2;
`else
    localparam int LZ64 = 18;
    localparam int LZ32 = 10;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        ena;
    logic        uns;
    logic        rv;
    logic        resid;
    logic [63:0] a1;
    logic [63:0] a2;
    logic [63:0] res4, res2, res1;
    logic        vld4, vld2, vld1;
    logic        busy4, busy2, busy1;

    int          n_chk = 0;
    int          n_pass = 0;
    int          lat, l4, l2, l1;
    logic [63:0] res, r4, r2, r1, x, y;
    logic        u, r, rs, seen;

    always #5 clk = ~clk;

    int_div_radix #(.WIDTH(64), .STEP(4)) dut (
        .i_clk(clk), .i_nrst(nrst), .i_ena(ena), .i_unsigned(uns), .i_rv32(rv),
        .i_residual(resid), .i_a1(a1), .i_a2(a2), .o_res(res4), .o_valid(vld4), .o_busy(busy4));
    int_div_radix #(.WIDTH(64), .STEP(2)) dut_s2 (
        .i_clk(clk), .i_nrst(nrst), .i_ena(ena), .i_unsigned(uns), .i_rv32(rv),
        .i_residual(resid), .i_a1(a1), .i_a2(a2), .o_res(res2), .o_valid(vld2), .o_busy(busy2));
    int_div_radix #(.WIDTH(64), .STEP(1)) dut_s1 (
        .i_clk(clk), .i_nrst(nrst), .i_ena(ena), .i_unsigned(uns), .i_rv32(rv),
        .i_residual(resid), .i_a1(a1), .i_a2(a2), .o_res(res1), .o_valid(vld1), .o_busy(busy1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_div(input logic [63:0] xa, input logic [63:0] yb,
                                            input logic fu, input logic fr, input logic frs);
        logic [31:0] a, b, q32, m32, s32;
        logic [63:0] q, m;
        int          sa, sb;
        longint      sx, sy;
        if (fr) begin
            a = xa[31:0];
            b = yb[31:0];
            if (b == 32'd0) begin q32 = '1; m32 = a; end
            else if (!fu && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin q32 = a; m32 = '0; end
            else if (fu) begin q32 = a / b; m32 = a % b; end
            else begin sa = a; sb = b; q32 = sa / sb; m32 = sa % sb; end
            s32 = frs ? m32 : q32;
            return {{32{s32[31]}}, s32};
        end
        if (yb == 64'd0) begin q = '1; m = xa; end
        else if (!fu && xa == 64'h8000_0000_0000_0000 && yb == '1) begin q = xa; m = '0; end
        else if (fu) begin q = xa / yb; m = xa % yb; end
        else begin sx = xa; sy = yb; q = sx / sy; m = sx % sy; end
        return frs ? m : q;
    endfunction

    function automatic int exp_lat(input logic [63:0] xa, input logic [63:0] yb,
                                   input logic fu, input logic fr);
        logic sp;
        if (fr) sp = (yb[31:0] == 32'd0) ||
                     (!fu && xa[31:0] == 32'h8000_0000 && yb[31:0] == 32'hFFFF_FFFF);
        else    sp = (yb == 64'd0) || (!fu && xa == 64'h8000_0000_0000_0000 && yb == '1);
        if (sp) return fr ? LZ32 : LZ64;
        return fr ? 10 : 18;
    endfunction

    task automatic run_op(input logic [63:0] xa, input logic [63:0] yb, input logic fu,
                          input logic fr, input logic frs, output int olat, output logic [63:0] ores);
        a1 = xa; a2 = yb; uns = fu; rv = fr; resid = frs; ena = 1'b1;
        tick();
        ena  = 1'b0;
        olat = -1;
        ores = '0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (vld4) begin
                olat = c;
                ores = res4;
                break;
            end
        end
    endtask

    task automatic dir(input string tag, input logic [63:0] xa, input logic [63:0] yb,
                       input logic fu, input logic fr, input logic frs,
                       input logic [63:0] exp, input int el);
        int          dl;
        logic [63:0] dres;
        run_op(xa, yb, fu, fr, frs, dl, dres);
        chk({tag, ".res"}, dres, exp);
        chk({tag, ".lat"}, 64'(dl), 64'(el));
    endtask

    initial begin
        nrst = 1'b0; ena = 1'b0; uns = 1'b0; rv = 1'b0; resid = 1'b0; a1 = '0; a2 = '0;
        repeat (3) tick();
        chk("rst.valid", 64'(vld4), 64'd0);
        chk("rst.busy", 64'(busy4), 64'd0);
        chk("rst.res", res4, 64'd0);
        nrst = 1'b1;
        tick();

        dir("s64.q",      64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF2, 18);
        dir("s64.r",      64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 18);
        dir("s64.pn.q",   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF2, 18);
        dir("s64.pn.r",   64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 0, 0, 1, 64'd2, 18);
        dir("s64.nn.q",   64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 0, 0, 0, 64'd14, 18);
        dir("rv.u",       64'h0000_0000_FFFF_FFFF, 64'd2, 1, 1, 0, 64'h0000_0000_7FFF_FFFF, 10);
        dir("rv.u.sext",  64'h0000_0000_FFFF_FFFF, 64'd1, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 10);
        dir("rv.ovf",     64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0,
            64'hFFFF_FFFF_8000_0000, LZ32);
        dir("rv.hi",      64'h1234_5678_FFFF_FF9C, 64'd7, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF2, 10);
        dir("dz.q",       64'd5, 64'd0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, LZ64);
        dir("dz.r",       64'd5, 64'd0, 0, 0, 1, 64'd5, LZ64);
        dir("dz.neg.r",   64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFB, LZ64);
        dir("ovf.q",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0,
            64'h8000_0000_0000_0000, LZ64);
        dir("ovf.r",      64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 64'd0, LZ64);
        dir("u.big.q",    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 64'd0, 18);

        // ignored start pulses during a busy period, then a back-to-back accept
        a1 = 64'd100; a2 = 64'd7; uns = 1'b1; rv = 1'b0; resid = 1'b0; ena = 1'b1;
        tick();
        lat = -1;
        res = '0;
        for (int c = 1; c <= 40; c++) begin
            ena = (c == 3 || c == 9);
            a1  = 64'd999;
            a2  = 64'd2;
            tick();
            if (c == 17) chk("hs.busy17", 64'(busy4), 64'd1);
            if (vld4) begin
                lat = c;
                res = res4;
                break;
            end
        end
        ena = 1'b0;
        chk("hs.lat", 64'(lat), 64'd18);
        chk("hs.res", res, 64'd14);
        chk("hs.busy_at_valid", 64'(busy4), 64'd0);
        dir("hs.b2b", 64'd200, 64'd7, 1, 0, 0, 64'd28, 18);
        tick();
        chk("hs.strobe", 64'(vld4), 64'd0);
        tick();
        tick();
        chk("hs.hold", res4, 64'd28);

        // reset in the middle of an operation
        a1 = 64'd1000; a2 = 64'd3; uns = 1'b1; ena = 1'b1;
        tick();
        ena = 1'b0;
        repeat (5) tick();
        nrst = 1'b0;
        #1;
        chk("mid.valid", 64'(vld4), 64'd0);
        chk("mid.busy", 64'(busy4), 64'd0);
        chk("mid.res", res4, 64'd0);
        repeat (2) tick();
        nrst = 1'b1;
        seen = 1'b0;
        repeat (25) begin
            tick();
            if (vld4) seen = 1'b1;
        end
        chk("mid.novalid", 64'(seen), 64'd0);
        dir("mid.next", 64'd100, 64'd7, 1, 0, 0, 64'd14, 18);

        // STEP sweep on all three instances from idle
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        tick();
        a1 = 64'h7FFF_FFFF_FFFF_FFFF; a2 = 64'd3; uns = 1'b0; rv = 1'b0; resid = 1'b0; ena = 1'b1;
        tick();
        ena = 1'b0;
        l4 = -1; l2 = -1; l1 = -1; r4 = '0; r2 = '0; r1 = '0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            if (vld4 && l4 < 0) begin l4 = c; r4 = res4; end
            if (vld2 && l2 < 0) begin l2 = c; r2 = res2; end
            if (vld1 && l1 < 0) begin l1 = c; r1 = res1; end
        end
        chk("sw4.lat", 64'(l4), 64'd18);
        chk("sw4.res", r4, 64'h2AAA_AAAA_AAAA_AAAA);
        chk("sw2.lat", 64'(l2), 64'd34);
        chk("sw2.res", r2, 64'h2AAA_AAAA_AAAA_AAAA);
        chk("sw1.lat", 64'(l1), 64'd66);
        chk("sw1.res", r1, 64'h2AAA_AAAA_AAAA_AAAA);
        chk("sw.idle", 64'({busy2, busy1}), 64'd0);

        // random operands against the reference model
        for (int i = 0; i < 2000; i++) begin
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom};
            u  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: y = '0;
                1: y = '1;
                2: y = y >> $urandom_range(0, 63);
                3: begin x = 64'h8000_0000_0000_0000; y = '1; end
                4: begin x[31:0] = 32'h8000_0000; y[31:0] = 32'hFFFF_FFFF; end
                5: x = x >> $urandom_range(0, 63);
                default: ;
            endcase
            run_op(x, y, u, r, rs, lat, res);
            chk("rand.res", res, ref_div(x, y, u, r, rs));
            chk("rand.lat", 64'(lat), 64'(exp_lat(x, y, u, r)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
